// File: rtl/cpu_sequencer_if.sv
// Bus between the accumulator-machine sequencer and its surroundings:
// run/step/halt controls, the opcode and PC it watches, and the per-phase
// enables plus status it produces.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             step;
    logic             resume;
    logic [4:0]       opcode;
    logic [7:0]       pc;
    logic [7:0]       bp_addr;
    logic             ir_load;
    logic             wb_en;
    logic             pc_inc;
    logic             busy;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        output run, step, resume, opcode, pc, bp_addr,
        input  ir_load, wb_en, pc_inc, busy, halted, state, retired
    );

    modport slave (
        input  run, step, resume, opcode, pc, bp_addr,
        output ir_load, wb_en, pc_inc, busy, halted, state, retired
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the 8-bit accumulator computer.
// One free-running clock; the FSM walks FETCH -> DECODE -> EXEC(xEXEC_CYCLES)
// -> WB and issues the IR latch, register write-back and PC advance enables.
// Supports free run, single step (one instruction per step rising edge),
// halt on HALT_OPCODE with resume, and a wrapping retired-instruction count.
// Optional feature macro: SEQ_BREAKPOINT_EN adds a PC breakpoint that halts
// after FETCH and lets the breakpointed instruction run once after resume.
module cpu_sequencer #(
    parameter logic [4:0] HALT_OPCODE = 5'h1F,
    parameter int          EXEC_CYCLES = 1,
    parameter int          CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } seqState_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    seqState_t        stateQ;
    logic             stepQ;
    logic             singleStep;
    logic [3:0]       execCnt;
    logic [CNT_W-1:0] retiredCnt;
    logic             stepRise;
    logic             bpHit;

    assign stepRise = bus.step & ~stepQ;

`ifdef SEQ_BREAKPOINT_EN
    logic bpSkip;

    assign bpHit = (bus.pc == bus.bp_addr) && !bpSkip;

    // Let the instruction we just resumed onto pass its breakpoint once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bpSkip <= 1'b0;
        end else if (stateQ == HALTED && bus.resume) begin
            bpSkip <= 1'b1;
        end else if (stateQ == WB) begin
            bpSkip <= 1'b0;
        end
    end
`else
    logic unusedBp;

    assign bpHit    = 1'b0;
    assign unusedBp = ^{bus.pc, bus.bp_addr};
`endif

    // Step edge detector history, tracked in every state so rises outside IDLE are lost
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stepQ <= 1'b0;
        end else begin
            stepQ <= bus.step;
        end
    end

    // Instruction phase FSM with EXEC settle counter and retire count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ     <= IDLE;
            singleStep <= 1'b0;
            execCnt    <= 4'd0;
            retiredCnt <= '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (bus.run) begin
                        stateQ     <= FETCH;
                        singleStep <= 1'b0;
                    end else if (stepRise) begin
                        stateQ     <= FETCH;
                        singleStep <= 1'b1;
                    end
                end
                FETCH: begin
                    stateQ <= bpHit ? HALTED : DECODE;
                end
                DECODE: begin
                    if (bus.opcode == HALT_OPCODE) begin
                        stateQ <= HALTED;
                    end else begin
                        stateQ  <= EXEC;
                        execCnt <= 4'd0;
                    end
                end
                EXEC: begin
                    if (execCnt == EXEC_LAST) begin
                        stateQ <= WB;
                    end else begin
                        execCnt <= execCnt + 4'd1;
                    end
                end
                WB: begin
                    retiredCnt <= retiredCnt + 1'b1;
                    stateQ     <= (bus.run && !singleStep) ? FETCH : IDLE;
                end
                HALTED: begin
                    if (bus.resume) begin
                        stateQ <= IDLE;
                    end
                end
                default: begin
                    stateQ <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs: every enable is a pure function of the state register
    assign bus.ir_load = (stateQ == FETCH);
    assign bus.wb_en   = (stateQ == WB);
    assign bus.pc_inc  = (stateQ == WB);
    assign bus.busy    = (stateQ == FETCH) || (stateQ == DECODE) ||
                         (stateQ == EXEC)  || (stateQ == WB);
    assign bus.halted  = (stateQ == HALTED);
    assign bus.state   = stateQ;
    assign bus.retired = retiredCnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer. The stimulus process drives inputs on
// the falling edge, advances an instruction-level reference model and queues
// the expected state/retire count; a monitor pops and compares after each
// rising edge. The bench also plays the PC register and instruction memory.
module tb_cpu_sequencer;

    localparam int         CNT_W       = 16;
    localparam int         EXEC_CYCLES = 1;
    localparam logic [4:0] HALT_OP     = 5'h1F;

    localparam int S_IDLE   = 0;
    localparam int S_FETCH  = 1;
    localparam int S_DECODE = 2;
    localparam int S_EXEC   = 3;
    localparam int S_WB     = 4;
    localparam int S_HALTED = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cpu_sequencer_if #(.CNT_W(CNT_W)) bus ();

    cpu_sequencer #(
        .HALT_OPCODE(HALT_OP),
        .EXEC_CYCLES(EXEC_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               st;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    // reference model: an instruction is a script of phases
    int               mState   = S_IDLE;
    int               plan[$];
    bit               mStepPrev = 1'b0;
    bit               mSingle   = 1'b0;
    bit               mBpSkip   = 1'b0;
    logic [CNT_W-1:0] mRetired  = '0;
    logic [7:0]       mPc       = 8'd0;
    logic [4:0]       prog[256];
    logic [7:0]       bpAddr    = 8'h05;
    int               nRetiredTotal = 0;
    int               nHaltsSeen    = 0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // a new instruction starts with FETCH; after FETCH it either decodes or
    // stops at the breakpoint
    function void beginInstr();
        bit hit;
        hit = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
        hit = (mPc == bpAddr) && !mBpSkip;
`endif
        mState = S_FETCH;
        plan.delete();
        plan.push_back(hit ? S_HALTED : S_DECODE);
    endfunction

    function void modelStep(bit r, bit run, bit step, bit resume, logic [4:0] opc);
        bit rise;
        if (!r) begin
            mState    = S_IDLE;
            plan.delete();
            mStepPrev = 1'b0;
            mSingle   = 1'b0;
            mBpSkip   = 1'b0;
            mRetired  = '0;
            mPc       = 8'd0;
            return;
        end
        rise      = step && !mStepPrev;
        mStepPrev = step;
        if (mState == S_IDLE) begin
            if (run || rise) begin
                mSingle = !run;
                beginInstr();
            end
        end else if (mState == S_HALTED) begin
            if (resume) begin
                mState  = S_IDLE;
                mBpSkip = 1'b1;
            end
        end else if (mState == S_WB) begin
            mRetired = mRetired + 1'b1;
            nRetiredTotal++;
            mPc      = mPc + 8'd1;
            mBpSkip  = 1'b0;
            if (run && !mSingle) beginInstr();
            else mState = S_IDLE;
        end else if (mState == S_DECODE) begin
            if (opc == HALT_OP) begin
                mState = S_HALTED;
            end else begin
                mState = S_EXEC;
                plan.delete();
                for (int i = 1; i < EXEC_CYCLES; i++) plan.push_back(S_EXEC);
                plan.push_back(S_WB);
            end
        end else begin
            mState = plan.pop_front();
        end
        if (mState == S_HALTED) nHaltsSeen++;
    endfunction

    task automatic cyc(input bit r, input bit run, input bit step, input bit resume);
        exp_t e;
        @(negedge clk);
        rst_n       = r;
        bus.run     = run;
        bus.step    = step;
        bus.resume  = resume;
        bus.opcode  = prog[mPc];
        bus.pc      = mPc;
        bus.bp_addr = bpAddr;
        modelStep(r, run, step, resume, prog[mPc]);
        e.st  = mState;
        e.ret = mRetired;
        expQ.push_back(e);
    endtask

    task automatic fillProg(input logic [4:0] op);
        for (int i = 0; i < 256; i++) prog[i] = op;
    endtask

    // Monitor: compare every presented output against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("state",   32'(bus.state),   32'(e.st));
                chk("ir_load", 32'(bus.ir_load), 32'(e.st == S_FETCH));
                chk("wb_en",   32'(bus.wb_en),   32'(e.st == S_WB));
                chk("pc_inc",  32'(bus.pc_inc),  32'(e.st == S_WB));
                chk("busy",    32'(bus.busy),    32'(e.st >= S_FETCH && e.st <= S_WB));
                chk("halted",  32'(bus.halted),  32'(e.st == S_HALTED));
                chk("retired", 32'(bus.retired), 32'(e.ret));
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        bit runR, stepR;
        logic [7:0] haltPc;
        bus.run     = 1'b1;
        bus.step    = 1'b0;
        bus.resume  = 1'b0;
        bus.opcode  = 5'h01;
        bus.pc      = 8'd0;
        bus.bp_addr = bpAddr;
        fillProg(5'h01);

        // reset with run held, then free-run three-plus instructions
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (14) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // single step: held step gives one instruction, a new edge another
        repeat (10) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // halt opcode: reset then third instruction halts; resume; re-halt
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        prog[2] = HALT_OP;
        haltPc = 8'd2;
        repeat (16) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        prog[haltPc] = 5'h01;
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // breakpoint walk: hit pc=5, resume, wrap around and hit it again
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (30) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (1060) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // reset while in EXEC of the first instruction aborts it
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // randomized traffic with occasional halts, resets and breakpoints
        for (int i = 0; i < 256; i++)
            prog[i] = ($urandom_range(0, 7) == 0) ? HALT_OP : 5'($urandom_range(0, 30));
`ifndef SEQ_BREAKPOINT_EN
        bpAddr = 8'($urandom_range(0, 255));
`endif
        runR  = 1'b0;
        stepR = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) runR = ~runR;
            if ($urandom_range(0, 5) == 0) stepR = ~stepR;
            cyc(($urandom_range(0, 199) != 0), runR, stepR, ($urandom_range(0, 9) == 0));
        end

        @(negedge clk);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
